// File: rtl/apb_uart_arbiter_if.sv
// APB bus bundle between the UART arbiter (master) and the UART APB bridge (slave).
interface apb_uart_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_uart_arbiter.sv
// Two-requester round-robin APB master sharing one UART APB bridge.
// Drives SETUP/ACCESS, returns read data / error, and aborts an ACCESS phase
// that waits too long for pready so the bus can never lock up.
module apb_uart_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int TO_WIDTH   = 4
) (
  input  logic                  pclk,
  input  logic                  prstn,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_done,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_err,
  apb_uart_arbiter_if.master    apb
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam logic [TO_WIDTH-1:0] WAIT_MAX = {TO_WIDTH{1'b1}};
  localparam logic [TO_WIDTH-1:0] WAIT_ONE = {{(TO_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;  // also owner of the transfer in flight
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [TO_WIDTH-1:0]   wait_q, wait_d;
  logic [1:0]            ready_q, ready_d;
  logic [1:0]            done_q, done_d;
  logic [1:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic                  gnt_s;
  logic                  finish_s;
  logic [DATA_WIDTH-1:0] res_rdata_s;
  logic                  res_err_s;
  logic [TO_WIDTH-1:0]   wait_inc_s;

  // Next-state, arbitration and next-output computation for every register.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    wait_d       = wait_q;
    ready_d      = 2'b00;
    done_d       = 2'b00;
    err_d        = err_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    gnt_s        = 1'b0;
    finish_s     = 1'b0;
    res_rdata_s  = {DATA_WIDTH{1'b0}};
    res_err_s    = 1'b0;
    wait_inc_s   = wait_q + WAIT_ONE;

    case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (req0_valid || req1_valid) begin
          // On a tie the requester that did not own the last grant wins.
          if (req0_valid && req1_valid) begin
            gnt_s = ~last_grant_q;
          end else begin
            gnt_s = req1_valid;
          end
          last_grant_d = gnt_s;
          if (gnt_s) begin
            paddr_d  = req1_addr;
            pwrite_d = req1_write;
            pwdata_d = req1_wdata;
          end else begin
            paddr_d  = req0_addr;
            pwrite_d = req0_write;
            pwdata_d = req0_wdata;
          end
          wait_d         = {TO_WIDTH{1'b0}};
          psel_d         = 1'b1;
          ready_d[gnt_s] = 1'b1;
          state_d        = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb.pready) begin
          finish_s    = 1'b1;
          res_rdata_s = pwrite_q ? {DATA_WIDTH{1'b0}} : apb.prdata;
          res_err_s   = apb.pslverr;
        end else if (wait_inc_s == WAIT_MAX) begin
          // Slave never answered: abort with an error so the requester moves on.
          finish_s    = 1'b1;
          res_rdata_s = {DATA_WIDTH{1'b0}};
          res_err_s   = 1'b1;
        end else begin
          wait_d = wait_inc_s;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    if (finish_s) begin
      psel_d                = 1'b0;
      penable_d             = 1'b0;
      state_d               = ST_IDLE;
      done_d[last_grant_q]  = 1'b1;
      err_d[last_grant_q]   = res_err_s;
      if (last_grant_q) begin
        rdata1_d = res_rdata_s;
      end else begin
        rdata0_d = res_rdata_s;
      end
    end else begin
      done_d = 2'b00;
    end
  end

  // State and registered outputs; reset drops the bus and any transfer in flight.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      paddr_q      <= {ADDR_WIDTH{1'b0}};
      pwrite_q     <= 1'b0;
      pwdata_q     <= {DATA_WIDTH{1'b0}};
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      wait_q       <= {TO_WIDTH{1'b0}};
      ready_q      <= 2'b00;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      rdata0_q     <= {DATA_WIDTH{1'b0}};
      rdata1_q     <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      wait_q       <= wait_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign apb.paddr   = paddr_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;

  assign req0_ready = ready_q[0];
  assign req1_ready = ready_q[1];
  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_apb_uart_arbiter.sv
// Self-checking bench for apb_uart_arbiter: directed scenarios followed by
// randomized transfers, checked against a transaction-level reference model.
module tb_apb_uart_arbiter;
  localparam int AW = 32;
  localparam int DW = 8;
  localparam int TO_LIMIT = 15;

  logic          pclk;
  logic          prstn;
  logic          req0_valid, req0_write, req0_ready, req0_done, req0_err;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic          req1_valid, req1_write, req1_ready, req1_done, req1_err;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_rdata;

  apb_uart_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  apb_uart_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TO_WIDTH(4)) dut (
    .pclk(pclk), .prstn(prstn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .apb(apb)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: who owned the last grant, and per-requester result registers.
  int            m_last;
  logic [DW-1:0] m_rdata [2];
  logic          m_err   [2];

  // Stimulus fields for each requester.
  logic          s_write [2];
  logic [AW-1:0] s_addr  [2];
  logic [DW-1:0] s_wdata [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fields();
    req0_write = s_write[0]; req0_addr = s_addr[0]; req0_wdata = s_wdata[0];
    req1_write = s_write[1]; req1_addr = s_addr[1]; req1_wdata = s_wdata[1];
  endtask

  task automatic model_reset();
    m_last = 1;
    m_rdata[0] = 8'h00; m_rdata[1] = 8'h00;
    m_err[0] = 1'b0;    m_err[1] = 1'b0;
  endtask

  task automatic chk_results(input string tag);
    chk({tag, "_rdata0"}, req0_rdata, m_rdata[0]);
    chk({tag, "_rdata1"}, req1_rdata, m_rdata[1]);
    chk({tag, "_err0"}, req0_err, m_err[0]);
    chk({tag, "_err1"}, req1_err, m_err[1]);
  endtask

  // One complete transfer starting from a negedge in an IDLE cycle.
  // w = number of pready-low ACCESS cycles before pready rises (>=15 means never).
  task automatic run_xfer(input bit v0, input bit v1, input int w,
                          input logic [DW-1:0] rd, input logic se, input bit hold);
    int            win;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_write;
    bit            last_cycle;
    if (v0 && v1) win = 1 - m_last;
    else          win = v1 ? 1 : 0;
    e_addr = s_addr[win]; e_wdata = s_wdata[win]; e_write = s_write[win];
    drive_fields();
    req0_valid = v0; req1_valid = v1;
    @(negedge pclk);
    // SETUP cycle
    m_last = win;
    chk("setup_psel", apb.psel, 1'b1);
    chk("setup_penable", apb.penable, 1'b0);
    chk("setup_ready0", req0_ready, (win == 0));
    chk("setup_ready1", req1_ready, (win == 1));
    chk("setup_done0", req0_done, 1'b0);
    chk("setup_done1", req1_done, 1'b0);
    chk("setup_paddr", apb.paddr, e_addr);
    chk("setup_pwrite", apb.pwrite, e_write);
    chk("setup_pwdata", apb.pwdata, e_wdata);
    if (!hold) begin
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
    end
    s_addr[0] = $urandom; s_addr[1] = $urandom;
    s_wdata[0] = 8'($urandom); s_wdata[1] = 8'($urandom);
    s_write[0] = 1'($urandom); s_write[1] = 1'($urandom);
    drive_fields();
    apb.pready = 1'($urandom); apb.prdata = 8'($urandom); apb.pslverr = 1'($urandom);
    @(negedge pclk);
    for (int k = 0; k < TO_LIMIT; k++) begin
      chk("access_psel", apb.psel, 1'b1);
      chk("access_penable", apb.penable, 1'b1);
      chk("access_paddr", apb.paddr, e_addr);
      chk("access_pwdata", apb.pwdata, e_wdata);
      chk("access_pwrite", apb.pwrite, e_write);
      chk("access_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("access_done", {30'd0, req1_done, req0_done}, 32'd0);
      apb.pready  = (k == w);
      apb.prdata  = rd;
      apb.pslverr = se;
      last_cycle  = (k == w) || (k == TO_LIMIT - 1);
      if (!hold) begin
        req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      end
      @(negedge pclk);
      if (last_cycle) break;
    end
    if (w < TO_LIMIT) begin
      m_err[win]   = se;
      m_rdata[win] = e_write ? 8'h00 : rd;
    end else begin
      m_err[win]   = 1'b1;
      m_rdata[win] = 8'h00;
    end
    apb.pready = 1'($urandom);
    // Completion IDLE cycle
    chk("done_psel", apb.psel, 1'b0);
    chk("done_penable", apb.penable, 1'b0);
    chk("done_done0", req0_done, (win == 0));
    chk("done_done1", req1_done, (win == 1));
    chk("done_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk_results("done");
  endtask

  initial begin
    int v0, v1, w;
    prstn = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    s_write[0] = 1'b0; s_write[1] = 1'b0;
    s_addr[0] = 32'h0; s_addr[1] = 32'h0;
    s_wdata[0] = 8'h0; s_wdata[1] = 8'h0;
    drive_fields();
    apb.pready = 1'b0; apb.prdata = 8'h00; apb.pslverr = 1'b0;
    model_reset();
    @(negedge pclk); @(negedge pclk);
    // Reset state
    chk("rst_psel", apb.psel, 1'b0);
    chk("rst_penable", apb.penable, 1'b0);
    chk("rst_paddr", apb.paddr, 32'h0);
    chk("rst_pwdata", apb.pwdata, 8'h00);
    chk("rst_pwrite", apb.pwrite, 1'b0);
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("rst_done", {30'd0, req1_done, req0_done}, 32'd0);
    chk_results("rst");
    prstn = 1'b1;
    @(negedge pclk);
    chk("idle_psel", apb.psel, 1'b0);

    // Single zero-wait write from req0
    s_write[0] = 1'b1; s_addr[0] = 32'h3; s_wdata[0] = 8'hA5;
    run_xfer(1'b1, 1'b0, 0, 8'h77, 1'b1, 1'b0);

    // Read from req1 with three wait states
    req0_valid = 1'b0;
    s_write[1] = 1'b0; s_addr[1] = 32'h5; s_wdata[1] = 8'h11;
    run_xfer(1'b0, 1'b1, 3, 8'h3C, 1'b0, 1'b0);

    // Both held valid: grants alternate
    for (int i = 0; i < 8; i++) begin
      s_write[0] = 1'($urandom); s_addr[0] = $urandom; s_wdata[0] = 8'($urandom);
      s_write[1] = 1'($urandom); s_addr[1] = $urandom; s_wdata[1] = 8'($urandom);
      run_xfer(1'b1, 1'b1, i % 3, 8'($urandom), 1'($urandom), 1'b1);
    end

    // Timeout on a req0 read, then a normal transfer
    req1_valid = 1'b0;
    s_write[0] = 1'b0; s_addr[0] = 32'h40; s_wdata[0] = 8'h00;
    run_xfer(1'b1, 1'b0, 100, 8'hFF, 1'b0, 1'b0);
    s_write[0] = 1'b0; s_addr[0] = 32'h41;
    run_xfer(1'b1, 1'b0, 1, 8'h5A, 1'b0, 1'b0);
    s_write[1] = 1'b0; s_addr[1] = 32'h42;
    run_xfer(1'b0, 1'b1, 0, 8'hC3, 1'b1, 1'b0);

    // Reset during ACCESS of a req0 transfer
    req1_valid = 1'b0;
    s_write[0] = 1'b0; s_addr[0] = 32'h99; s_wdata[0] = 8'h00;
    drive_fields();
    req0_valid = 1'b1;
    apb.pready = 1'b0;
    @(negedge pclk);
    chk("mid_setup_ready0", req0_ready, 1'b1);
    req0_valid = 1'b0;
    @(negedge pclk);
    chk("mid_access_penable", apb.penable, 1'b1);
    @(negedge pclk);
    #1 prstn = 1'b0;
    #1;
    model_reset();
    chk("arst_psel", apb.psel, 1'b0);
    chk("arst_penable", apb.penable, 1'b0);
    chk("arst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("arst_done", {30'd0, req1_done, req0_done}, 32'd0);
    chk_results("arst");
    @(negedge pclk);
    prstn = 1'b1;
    chk("post_rst_psel", apb.psel, 1'b0);
    // Tie straight after reset must go to req0 again
    s_write[0] = 1'b0; s_addr[0] = 32'h7; s_write[1] = 1'b1; s_addr[1] = 32'h8;
    run_xfer(1'b1, 1'b1, 0, 8'h21, 1'b0, 1'b0);
    req0_valid = 1'b0;
    s_write[1] = 1'b0; s_addr[1] = 32'h9;
    run_xfer(1'b0, 1'b1, 2, 8'h9E, 1'b0, 1'b0);

    // Randomized transfers
    for (int i = 0; i < 40; i++) begin
      v0 = $urandom_range(0, 1);
      v1 = $urandom_range(0, 1);
      if (v0 == 0 && v1 == 0) v0 = 1;
      if ($urandom_range(0, 5) == 0) w = $urandom_range(12, 17);
      else                           w = $urandom_range(0, 4);
      s_write[0] = 1'($urandom); s_addr[0] = $urandom; s_wdata[0] = 8'($urandom);
      s_write[1] = 1'($urandom); s_addr[1] = $urandom; s_wdata[1] = 8'($urandom);
      run_xfer(v0[0], v1[0], w, 8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge pclk);
        chk("gap_psel", apb.psel, 1'b0);
        chk("gap_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
